// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers.
// A credit counter mirrors FIFO occupancy, so no write is ever issued into a full FIFO.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CRED_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_rd_pop,
  output logic                      wr,
  output logic [DATA_W-1:0]         data_in,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic [CRED_W-1:0]         credits,
  output logic                      acct_err
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic              grant_valid_q, grant_valid_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              acct_err_q, acct_err_d;

  logic              owner_ready;
  logic              accept;
  logic              last_beat;
  logic              at_full_credit;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;

  // Scan last+1, last+2, ... so the most recent owner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    cand   = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign owner_ready    = (state_q == BURST) && !rst && (credits_q != '0) && !fifo_full;
  assign accept         = owner_ready && req_valid[owner_q];
  assign last_beat      = (burst_cnt_q == BC_W'(MAX_BURST - 1));
  assign at_full_credit = (credits_q == CRED_W'(DEPTH));

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = owner_ready;
  end

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    burst_cnt_d   = burst_cnt_q;
    grant_valid_d = grant_valid_q;
    wr_d          = accept;
    data_in_d     = accept ? req_data[int'(owner_q)*DATA_W +: DATA_W] : data_in_q;
    credits_d     = credits_q;
    acct_err_d    = acct_err_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BURST;
          owner_d       = winner;
          burst_cnt_d   = '0;
          grant_valid_d = 1'b1;
        end
      end
      BURST: begin
        if (accept) burst_cnt_d = burst_cnt_q + BC_W'(1);
        if (!req_valid[owner_q] || (accept && last_beat)) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          last_d        = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop against an empty-by-accounting FIFO is flagged and never lifts credits past DEPTH.
    if (accept && !fifo_rd_pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!accept && fifo_rd_pop && !at_full_credit) begin
      credits_d = credits_q + CRED_W'(1);
    end
    if (fifo_rd_pop && at_full_credit) acct_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_q        <= ID_W'(NUM_REQ - 1);
      burst_cnt_q   <= '0;
      grant_valid_q <= 1'b0;
      wr_q          <= 1'b0;
      data_in_q     <= '0;
      credits_q     <= CRED_W'(DEPTH);
      acct_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      burst_cnt_q   <= burst_cnt_d;
      grant_valid_q <= grant_valid_d;
      wr_q          <= wr_d;
      data_in_q     <= data_in_d;
      credits_q     <= credits_d;
      acct_err_q    <= acct_err_d;
    end
  end

  assign wr          = wr_q;
  assign data_in     = data_in_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = owner_q;
  assign credits     = credits_q;
  assign acct_err    = acct_err_q;

endmodule
